// File: rtl/seconds_if.sv
// Seconds-to-minutes carry interface: count, one-cycle overflow carry and run status.
// SECONDS_BCD_EN adds the registered BCD digit outputs.
interface seconds_if #(
  parameter int CNT_W = 7
);
  logic [CNT_W-1:0] countsec;
  logic             overflow;
  logic             runsec;
`ifdef SECONDS_BCD_EN
  logic [3:0]       sectens;
  logic [3:0]       secones;
`endif

`ifdef SECONDS_BCD_EN
  modport master (output countsec, overflow, runsec, sectens, secones);
  modport slave  (input  countsec, overflow, runsec, sectens, secones);
`else
  modport master (output countsec, overflow, runsec);
  modport slave  (input  countsec, overflow, runsec);
`endif
endinterface

// File: rtl/seconds.sv
// Stopwatch seconds stage: 0..MAX_COUNT counter with run/pause/adjust and a one-cycle carry.
// Optional macro SECONDS_BCD_EN adds lockstep BCD digit counters (sectens/secones).
module seconds #(
  parameter int MAX_COUNT = 59,
  parameter int CNT_W     = 7
) (
  input  logic       clksec,
  input  logic       rstsec,
  input  logic       tick1hz,
  input  logic       tick2hz,
  input  logic       pausesec,
  input  logic       adjsec,
  input  logic       selsec,
  seconds_if.master  carry
);

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    PAUSED = 2'b01,
    ADJUST = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_COUNT);

  state_t           state;
  logic             saved_run;
  logic [CNT_W-1:0] count;
  logic             ovf;
  logic             run_q;
  logic             at_end;
  logic             is_max;
`ifdef SECONDS_BCD_EN
  logic [3:0]       tens;
  logic [3:0]       ones;
`endif

  // Anything at or beyond the terminal count wraps to 0; only an exact terminal count carries.
  assign at_end = (count >= MAX_C);
  assign is_max = (count == MAX_C);

  always_ff @(posedge clksec) begin
    if (rstsec) begin
      state     <= PAUSED;
      saved_run <= 1'b0;
      count     <= '0;
      ovf       <= 1'b0;
      run_q     <= 1'b0;
`ifdef SECONDS_BCD_EN
      tens      <= 4'd0;
      ones      <= 4'd0;
`endif
    end else begin
      ovf <= 1'b0;
      case (state)
        PAUSED: begin
          if (adjsec) begin
            state     <= ADJUST;
            saved_run <= pausesec;
            run_q     <= 1'b0;
          end else if (pausesec) begin
            state <= RUN;
            run_q <= 1'b1;
          end
        end

        RUN: begin
          if (tick1hz) begin
            count <= at_end ? '0 : count + CNT_W'(1);
            ovf   <= is_max;
`ifdef SECONDS_BCD_EN
            if (at_end) begin
              tens <= 4'd0;
              ones <= 4'd0;
            end else if (ones == 4'd9) begin
              ones <= 4'd0;
              tens <= tens + 4'd1;
            end else begin
              ones <= ones + 4'd1;
            end
`endif
          end
          if (adjsec) begin
            state     <= ADJUST;
            saved_run <= ~pausesec;
            run_q     <= 1'b0;
          end else if (pausesec) begin
            state <= PAUSED;
            run_q <= 1'b0;
          end
        end

        ADJUST: begin
          if (selsec && tick2hz) begin
            count <= at_end ? '0 : count + CNT_W'(1);
`ifdef SECONDS_BCD_EN
            if (at_end) begin
              tens <= 4'd0;
              ones <= 4'd0;
            end else if (ones == 4'd9) begin
              ones <= 4'd0;
              tens <= tens + 4'd1;
            end else begin
              ones <= ones + 4'd1;
            end
`endif
          end
          if (pausesec) begin
            saved_run <= ~saved_run;
          end
          // On release, a pause arriving in the same cycle still flips the resume target.
          if (!adjsec) begin
            if (saved_run ^ pausesec) begin
              state <= RUN;
              run_q <= 1'b1;
            end else begin
              state <= PAUSED;
              run_q <= 1'b0;
            end
          end
        end

        default: begin
          state <= PAUSED;
          run_q <= 1'b0;
        end
      endcase
    end
  end

  assign carry.countsec = count;
  assign carry.overflow = ovf;
  assign carry.runsec   = run_q;
`ifdef SECONDS_BCD_EN
  assign carry.sectens  = tens;
  assign carry.secones  = ones;
`endif

endmodule

// File: tb/tb_seconds.sv
// Directed self-checking bench for the seconds stage; BCD checks compile in with SECONDS_BCD_EN.
module tb_seconds;

  logic clksec = 1'b0;
  logic rstsec, tick1hz, tick2hz, pausesec, adjsec, selsec;
  int   n_cmp  = 0;
  int   n_fail = 0;

  seconds_if #(.CNT_W(7)) sif ();

  seconds #(.MAX_COUNT(59), .CNT_W(7)) dut (
    .clksec   (clksec),
    .rstsec   (rstsec),
    .tick1hz  (tick1hz),
    .tick2hz  (tick2hz),
    .pausesec (pausesec),
    .adjsec   (adjsec),
    .selsec   (selsec),
    .carry    (sif)
  );

  always #5 clksec = ~clksec;

  // One clock of stimulus; outputs are sampled 1 time unit after the rising edge.
  task automatic cycle(input logic t1, input logic t2, input logic p);
    tick1hz  = t1;
    tick2hz  = t2;
    pausesec = p;
    @(posedge clksec);
    #1;
    tick1hz  = 1'b0;
    tick2hz  = 1'b0;
    pausesec = 1'b0;
  endtask

  task automatic test_reset();
    rstsec = 1'b1;
    cycle(1'b0, 1'b0, 1'b0);
    rstsec = 1'b0;
    n_cmp++;
    if (sif.countsec !== 7'd0 || sif.runsec !== 1'b0 || sif.overflow !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_state: count=%0d run=%b ovf=%b required 0/0/0",
               sif.countsec, sif.runsec, sif.overflow);
    end
`ifdef SECONDS_BCD_EN
    n_cmp++;
    if (sif.sectens !== 4'd0 || sif.secones !== 4'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_bcd: tens=%0d ones=%0d required 0/0", sif.sectens, sif.secones);
    end
`endif
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (sif.countsec !== 7'd0 || sif.runsec !== 1'b0 || sif.overflow !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL paused_tick%0d: count=%0d run=%b ovf=%b required 0/0/0",
                 i, sif.countsec, sif.runsec, sif.overflow);
      end
    end
  endtask

  task automatic test_run_wrap();
    logic [6:0] exp_cnt;
    cycle(1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (sif.runsec !== 1'b1 || sif.countsec !== 7'd0) begin
      n_fail++;
      $display("[TB] FAIL start_run: run=%b count=%0d required 1/0", sif.runsec, sif.countsec);
    end
    for (int i = 1; i <= 60; i++) begin
      exp_cnt = 7'(i % 60);
      cycle(1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (sif.countsec !== exp_cnt || sif.overflow !== (i == 60) || sif.runsec !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL run_tick%0d: count=%0d ovf=%b run=%b required %0d/%b/1",
                 i, sif.countsec, sif.overflow, sif.runsec, exp_cnt, (i == 60));
      end
`ifdef SECONDS_BCD_EN
      n_cmp++;
      if (sif.sectens !== 4'((i % 60) / 10) || sif.secones !== 4'((i % 60) % 10)) begin
        n_fail++;
        $display("[TB] FAIL run_bcd%0d: tens=%0d ones=%0d required %0d/%0d",
                 i, sif.sectens, sif.secones, (i % 60) / 10, (i % 60) % 10);
      end
`endif
      cycle(1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (sif.overflow !== 1'b0 || sif.countsec !== exp_cnt) begin
        n_fail++;
        $display("[TB] FAIL run_idle%0d: ovf=%b count=%0d required 0/%0d",
                 i, sif.overflow, sif.countsec, exp_cnt);
      end
    end
  endtask

  task automatic test_adjust_wrap();
    for (int i = 0; i < 59; i++) cycle(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (sif.countsec !== 7'd59) begin
      n_fail++;
      $display("[TB] FAIL reach59: count=%0d required 59", sif.countsec);
    end
    adjsec = 1'b1;
    selsec = 1'b1;
    cycle(1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (sif.runsec !== 1'b0 || sif.countsec !== 7'd59) begin
      n_fail++;
      $display("[TB] FAIL enter_adjust: run=%b count=%0d required 0/59", sif.runsec, sif.countsec);
    end
    cycle(1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (sif.countsec !== 7'd0 || sif.overflow !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL adjust_wrap: count=%0d ovf=%b required 0/0", sif.countsec, sif.overflow);
    end
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (sif.countsec !== 7'd5) begin
      n_fail++;
      $display("[TB] FAIL adjust_adv5: count=%0d required 5", sif.countsec);
    end
    adjsec = 1'b0;
    cycle(1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (sif.runsec !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL resume_run: run=%b required 1", sif.runsec);
    end
    cycle(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (sif.countsec !== 7'd6) begin
      n_fail++;
      $display("[TB] FAIL resume_tick: count=%0d required 6", sif.countsec);
    end
  endtask

  task automatic test_adjust_hold();
    adjsec = 1'b1;
    selsec = 1'b0;
    cycle(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (sif.countsec !== 7'd6 || sif.overflow !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL minutes_sel_hold: count=%0d ovf=%b required 6/0", sif.countsec, sif.overflow);
    end
    cycle(1'b0, 1'b0, 1'b1);
    adjsec = 1'b0;
    cycle(1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (sif.runsec !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL release_to_paused: run=%b required 0", sif.runsec);
    end
    cycle(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (sif.countsec !== 7'd6) begin
      n_fail++;
      $display("[TB] FAIL paused_after_adjust: count=%0d required 6", sif.countsec);
    end
  endtask

  task automatic test_simultaneous();
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (sif.countsec !== 7'd7) begin
      n_fail++;
      $display("[TB] FAIL both_strobes_run: count=%0d required 7", sif.countsec);
    end
    cycle(1'b1, 1'b0, 1'b1);
    n_cmp++;
    if (sif.countsec !== 7'd8 || sif.runsec !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL tick_and_pause: count=%0d run=%b required 8/0", sif.countsec, sif.runsec);
    end
    cycle(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (sif.countsec !== 7'd8) begin
      n_fail++;
      $display("[TB] FAIL paused_after_pause: count=%0d required 8", sif.countsec);
    end
  endtask

  task automatic test_reset_mid();
    cycle(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 51; i++) cycle(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (sif.countsec !== 7'd59) begin
      n_fail++;
      $display("[TB] FAIL reach59_again: count=%0d required 59", sif.countsec);
    end
    rstsec = 1'b1;
    cycle(1'b1, 1'b0, 1'b0);
    rstsec = 1'b0;
    n_cmp++;
    if (sif.countsec !== 7'd0 || sif.overflow !== 1'b0 || sif.runsec !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_at_wrap: count=%0d ovf=%b run=%b required 0/0/0",
               sif.countsec, sif.overflow, sif.runsec);
    end
    cycle(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (sif.countsec !== 7'd0 || sif.overflow !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL post_reset_paused: count=%0d ovf=%b required 0/0", sif.countsec, sif.overflow);
    end
  endtask

`ifdef SECONDS_BCD_EN
  task automatic test_bcd();
    cycle(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 47; i++) cycle(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (sif.sectens !== 4'd4 || sif.secones !== 4'd7 || sif.countsec !== 7'd47) begin
      n_fail++;
      $display("[TB] FAIL bcd47: tens=%0d ones=%0d count=%0d required 4/7/47",
               sif.sectens, sif.secones, sif.countsec);
    end
    for (int i = 0; i < 13; i++) cycle(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (sif.sectens !== 4'd0 || sif.secones !== 4'd0 || sif.overflow !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL bcd_wrap: tens=%0d ones=%0d ovf=%b required 0/0/1",
               sif.sectens, sif.secones, sif.overflow);
    end
  endtask
`endif

  initial begin
    rstsec   = 1'b1;
    tick1hz  = 1'b0;
    tick2hz  = 1'b0;
    pausesec = 1'b0;
    adjsec   = 1'b0;
    selsec   = 1'b0;
    #2;
    test_reset();
    test_run_wrap();
    test_adjust_wrap();
    test_adjust_hold();
    test_simultaneous();
    test_reset_mid();
`ifdef SECONDS_BCD_EN
    test_bcd();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/seconds.md
Name: seconds

Overview:
- Stopwatch seconds stage.
- Counts 0..59 on a 1 Hz strobe and supports pause and adjust.
- Drives the one-cycle overflow carry that the downstream minutes counter consumes on its overflow input.
- Sits between the clock-divider strobes and the minutes stage: it is the producing end of the seconds-to-minutes carry interface.

Parameters:
- MAX_COUNT, 59, terminal count; the value after MAX_COUNT is 0.
- CNT_W, 7, width of countsec; must satisfy 2**CNT_W > MAX_COUNT.

Ports:
- clksec  in  1  system clock; all logic on rising edge.
- rstsec  in  1  synchronous, active-high reset.
- tick1hz  in  1  one-clksec-cycle strobe, 1 Hz; advances the count in RUN.
- tick2hz  in  1  one-clksec-cycle strobe, 2 Hz; advances the count in ADJUST.
- pausesec  in  1  debounced one-cycle pulse; toggles run/paused.
- adjsec  in  1  level; adjust mode active.
- selsec  in  1  level; 1 = seconds selected for adjust, 0 = minutes selected (seconds hold).
- countsec  out  CNT_W  current seconds value, binary, registered.
- overflow  out  1  carry to minutes, registered, exactly one clksec cycle wide.
- runsec  out  1  1 while state is RUN.

Behaviour:
- Reset (rstsec=1 at a clock edge): state=PAUSED, saved run flag=0, countsec=0, overflow=0, runsec=0. Reset dominates every other input. Reset mid-count or mid-adjust aborts immediately, with no overflow pulse.
- States (2-bit encoding): RUN=00, PAUSED=01, ADJUST=10.
- PAUSED:
  - pausesec -> RUN.
  - adjsec=1 -> ADJUST, with saved flag=0.
  - Count holds.
- RUN:
  - On tick1hz: countsec = (countsec==MAX_COUNT) ? 0 : countsec+1.
  - pausesec -> PAUSED.
  - adjsec=1 -> ADJUST, with saved flag=1.
- ADJUST:
  - tick1hz is ignored.
  - If selsec=1, advance on tick2hz with the same wrap rule. If selsec=0, the count holds.
  - pausesec toggles the saved flag.
  - adjsec=0 -> RUN if saved flag=1, else PAUSED.
- Overflow:
  - Set in the same edge that wraps countsec from MAX_COUNT to 0 in RUN. It is visible together with countsec=0 and cleared on the next edge.
  - Never asserted by an ADJUST wrap, nor while PAUSED.
  - Minutes increments once per cycle that overflow is high, so a width above one cycle is a defect.
- Simultaneous events:
  - adjsec has priority over pausesec for the state transition. The pause is still applied to the saved flag.
  - pausesec and tick1hz in the same RUN cycle: the tick is counted and the state goes to PAUSED.
  - tick1hz and tick2hz coincident: only the strobe relevant to the current state acts.
- Latency: countsec, overflow and runsec all update on the edge where the strobe or pulse is sampled, one cycle after it is presented.
- Out-of-range protection: if countsec > MAX_COUNT (e.g. after a MAX_COUNT change), the next advance loads 0 with no overflow.
- State 11 is illegal and recovers to PAUSED on the next edge.

Optional Feature:
- Macro: SECONDS_BCD_EN.
- When defined:
  - Extra outputs sectens[3:0] and secones[3:0] give the BCD digits of countsec.
  - They are maintained as registered digit counters updated in lockstep with countsec, not produced by a divider.
  - Both are 0 on reset. The ones digit wraps 9->0 while the tens digit increments; both go to 0 on the MAX_COUNT wrap.
- When undefined: these ports and registers do not exist. All other behaviour is identical.

Test Plan:
- Reset then 3 pausesec-free tick1hz -> countsec stays 0, runsec=0, overflow never 1.
- pausesec, then 60 tick1hz -> countsec 1..59 then 0; overflow=1 for exactly one cycle, coincident with countsec=0; runsec=1.
- RUN at 59, assert adjsec+selsec, 1 tick2hz -> countsec=0, overflow stays 0. Then 5 tick2hz -> countsec=5. Deassert adjsec -> RUN resumes; next tick1hz -> 6.
- In ADJUST with selsec=0, apply 4 tick2hz and 4 tick1hz -> countsec unchanged. pausesec in ADJUST, then release adjsec from a RUN-saved state -> PAUSED.
- rstsec asserted in the cycle where countsec=59 and tick1hz=1 -> countsec=0, overflow=0, state PAUSED.
- With SECONDS_BCD_EN: count to 47 -> sectens=4, secones=7. Continue to wrap -> both 0 with overflow=1.
